// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Builds the staged, active-high reset fabric for the downstream shift and
//   register stages. Three request sources (board reset, PLL lock, software
//   request) are merged; the two asynchronous ones are synchronized first.
//   Once the merged request has been clean for STRETCH_CYCLES, the stage
//   resets are released one by one, STAGE_DLY cycles apart, bit 0 first.
//   Any new request re-asserts every stage on the same edge.
//
// Ports
//   clk               system clock, all logic on posedge
//   reset             synchronous, active-high block reset
//   ext_rst_n_async   board reset request, active-low, asynchronous
//   pll_locked_async  PLL lock, asynchronous, low requests reset
//   sw_rst_req        software reset request, synchronous, active-high
//   rst_out           per-stage reset, active-high, bit 0 releases first
//   rst_done          high once every stage is released
//   seq_busy          high in every state except DONE
module reset_sequencer #(
    parameter int N_STAGES       = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_DLY      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ext_rst_n_async,
    input  logic                pll_locked_async,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                rst_done,
    output logic                seq_busy
);

    localparam int CNT_MAX = ((STRETCH_CYCLES > STAGE_DLY) ? STRETCH_CYCLES : STAGE_DLY) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_STAGES < 2) ? 1 : $clog2(N_STAGES);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Synchronizer chains; cleared to 0 so both sources read as "request
    // reset" until real samples have walked through every flop.
    logic [SYNC_STAGES-1:0] ext_sync_reg;
    logic [SYNC_STAGES-1:0] lock_sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_sync_reg  <= '0;
            lock_sync_reg <= '0;
        end else begin
            ext_sync_reg  <= {ext_sync_reg[SYNC_STAGES-2:0], ext_rst_n_async};
            lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked_async};
        end
    end

    logic ext_sync;
    logic lock_sync;
    logic req;

    assign ext_sync  = ext_sync_reg[SYNC_STAGES-1];
    assign lock_sync = lock_sync_reg[SYNC_STAGES-1];
    assign req       = ~ext_sync | ~lock_sync | sw_rst_req;

    logic [1:0]          state_reg,    state_next;
    logic [CNT_W-1:0]    cnt_reg,      cnt_next;
    logic [IDX_W-1:0]    idx_reg,      idx_next;
    logic [N_STAGES-1:0] rst_out_reg,  rst_out_next;
    logic                rst_done_reg, rst_done_next;
    logic                seq_busy_reg, seq_busy_next;

    // One-hot mask of the stage addressed by idx_reg.
    logic [N_STAGES-1:0] idx_mask;

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_idx_mask
            assign idx_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        rst_out_next  = rst_out_reg;
        rst_done_next = rst_done_reg;
        seq_busy_next = seq_busy_reg;

        if (req && state_reg != ST_ASSERT) begin
            // Abort: every stage goes back into reset on this edge.
            state_next    = ST_ASSERT;
            cnt_next      = '0;
            idx_next      = '0;
            rst_out_next  = '1;
            rst_done_next = 1'b0;
            seq_busy_next = 1'b1;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    if (!req) begin
                        state_next = ST_STRETCH;
                        cnt_next   = '0;
                    end
                end
                ST_STRETCH: begin
                    if (cnt_reg == CNT_W'(STRETCH_CYCLES - 1)) begin
                        rst_out_next[0] = 1'b0;
                        cnt_next        = '0;
                        if (N_STAGES == 1) begin
                            state_next    = ST_DONE;
                            rst_done_next = 1'b1;
                            seq_busy_next = 1'b0;
                        end else begin
                            state_next = ST_RELEASE;
                            idx_next   = IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_reg == CNT_W'(STAGE_DLY - 1)) begin
                        rst_out_next = rst_out_reg & ~idx_mask;
                        cnt_next     = '0;
                        if (idx_reg == IDX_W'(N_STAGES - 1)) begin
                            state_next    = ST_DONE;
                            rst_done_next = 1'b1;
                            seq_busy_next = 1'b0;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: hold until a request arrives (handled above).
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_ASSERT;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            rst_out_reg  <= '1;
            rst_done_reg <= 1'b0;
            seq_busy_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            rst_out_reg  <= rst_out_next;
            rst_done_reg <= rst_done_next;
            seq_busy_reg <= seq_busy_next;
        end
    end

    assign rst_out  = rst_out_reg;
    assign rst_done = rst_done_reg;
    assign seq_busy = seq_busy_reg;

endmodule
